// File: rtl/ninjakun_psgbus_ctl_if.sv
// Host/PSG bus bundle for ninjakun_psgbus_ctl: request side, read-back and AY-3-8910 bus pins.
interface ninjakun_psgbus_ctl_if;
  logic       REQ;
  logic       REQWR;
  logic       REQCH;
  logic [3:0] REQRG;
  logic [7:0] REQDT;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RDDT;
  logic [7:0] PSGDA;
  logic       PSGDOE;
  logic [7:0] PSGDI;
  logic       PSGBDIR;
  logic       PSGBC1;
  logic       PSGCS0_L;
  logic       PSGCS1_L;

  modport master (
    output REQ, REQWR, REQCH, REQRG, REQDT, PSGDI,
    input  BUSY, DONE, RDDT, PSGDA, PSGDOE, PSGBDIR, PSGBC1, PSGCS0_L, PSGCS1_L
  );

  modport slave (
    input  REQ, REQWR, REQCH, REQRG, REQDT, PSGDI,
    output BUSY, DONE, RDDT, PSGDA, PSGDOE, PSGBDIR, PSGBC1, PSGCS0_L, PSGCS1_L
  );
endinterface

// File: rtl/ninjakun_psgbus_ctl.sv
// PSG bus sequencer: turns one register read/write request into the AY
// latch-address / gap / data / gap phase sequence on the selected chip.
module ninjakun_psgbus_ctl #(
  parameter int unsigned HOLD = 4
) (
  input logic                  SHCLK,
  input logic                  RESET_L,
  ninjakun_psgbus_ctl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_GAP2 = 3'd4;

  localparam logic [3:0] RELOAD = 4'(HOLD - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       lat_wr;
  logic [7:0] lat_dt;

  // Every output is assigned on the transition into the phase it belongs to,
  // so all pins are flops and no input reaches an output combinationally.
  always_ff @(posedge SHCLK) begin
    if (!RESET_L) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_wr       <= 1'b0;
      lat_dt       <= '0;
      bus.BUSY     <= 1'b0;
      bus.DONE     <= 1'b0;
      bus.RDDT     <= '0;
      bus.PSGDA    <= '0;
      bus.PSGDOE   <= 1'b0;
      bus.PSGBDIR  <= 1'b0;
      bus.PSGBC1   <= 1'b0;
      bus.PSGCS0_L <= 1'b1;
      bus.PSGCS1_L <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.REQ) begin
            state        <= ST_ADDR;
            cnt          <= RELOAD;
            lat_wr       <= bus.REQWR;
            lat_dt       <= bus.REQDT;
            bus.BUSY     <= 1'b1;
            bus.PSGBDIR  <= 1'b1;
            bus.PSGBC1   <= 1'b1;
            bus.PSGDA    <= {4'h0, bus.REQRG};
            bus.PSGDOE   <= 1'b1;
            bus.PSGCS0_L <= bus.REQCH;
            bus.PSGCS1_L <= ~bus.REQCH;
          end
        end
        ST_ADDR: begin
          if (cnt == '0) begin
            state       <= ST_GAP1;
            bus.PSGBDIR <= 1'b0;
            bus.PSGBC1  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GAP1: begin
          state <= ST_DATA;
          cnt   <= RELOAD;
          if (lat_wr) begin
            bus.PSGBDIR <= 1'b1;
            bus.PSGBC1  <= 1'b0;
            bus.PSGDA   <= lat_dt;
            bus.PSGDOE  <= 1'b1;
          end else begin
            bus.PSGBDIR <= 1'b0;
            bus.PSGBC1  <= 1'b1;
            bus.PSGDA   <= '0;
            bus.PSGDOE  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            state       <= ST_GAP2;
            bus.PSGBDIR <= 1'b0;
            bus.PSGBC1  <= 1'b0;
            bus.PSGDA   <= '0;
            bus.PSGDOE  <= 1'b0;
            bus.DONE    <= 1'b1;
            if (!lat_wr) begin
              bus.RDDT <= bus.PSGDI;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GAP2: begin
          state        <= ST_IDLE;
          bus.DONE     <= 1'b0;
          bus.BUSY     <= 1'b0;
          bus.PSGCS0_L <= 1'b1;
          bus.PSGCS1_L <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
